// File: rtl/bus_transfer_sequencer_pkg.sv
// Shared codes, widths, FSM encoding and one-hot helpers for the bus transfer sequencer.
package bus_transfer_sequencer_pkg;

  localparam int unsigned CODE_W = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned REQ_W  = 2 * CODE_W;
  localparam int unsigned NSRC   = 24;
  localparam int unsigned NDST   = 23;

  // Source out-enable indices
  localparam logic [CODE_W-1:0] SRC_R0     = CODE_W'(0);
  localparam logic [CODE_W-1:0] SRC_R15    = CODE_W'(15);
  localparam logic [CODE_W-1:0] SRC_HI     = CODE_W'(16);
  localparam logic [CODE_W-1:0] SRC_LO     = CODE_W'(17);
  localparam logic [CODE_W-1:0] SRC_ZHIGH  = CODE_W'(18);
  localparam logic [CODE_W-1:0] SRC_ZLOW   = CODE_W'(19);
  localparam logic [CODE_W-1:0] SRC_PC     = CODE_W'(20);
  localparam logic [CODE_W-1:0] SRC_MDR    = CODE_W'(21);
  localparam logic [CODE_W-1:0] SRC_INPORT = CODE_W'(22);
  localparam logic [CODE_W-1:0] SRC_C      = CODE_W'(23);

  // Destination in-enable indices
  localparam logic [CODE_W-1:0] DST_R0      = CODE_W'(0);
  localparam logic [CODE_W-1:0] DST_R15     = CODE_W'(15);
  localparam logic [CODE_W-1:0] DST_HI      = CODE_W'(16);
  localparam logic [CODE_W-1:0] DST_LO      = CODE_W'(17);
  localparam logic [CODE_W-1:0] DST_PC      = CODE_W'(18);
  localparam logic [CODE_W-1:0] DST_MDR     = CODE_W'(19);
  localparam logic [CODE_W-1:0] DST_MAR     = CODE_W'(20);
  localparam logic [CODE_W-1:0] DST_Y       = CODE_W'(21);
  localparam logic [CODE_W-1:0] DST_OUTPORT = CODE_W'(22);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_LATCH = 2'd2
  } xfer_state_e;

  typedef struct packed {
    logic [CODE_W-1:0] src;
    logic [CODE_W-1:0] dst;
  } xfer_req_t;

  function automatic logic code_legal(input logic [CODE_W-1:0] src,
                                      input logic [CODE_W-1:0] dst);
    return (src <= SRC_C) && (dst <= DST_OUTPORT);
  endfunction

  function automatic logic [NSRC-1:0] src_onehot(input logic [CODE_W-1:0] code);
    return NSRC'(1) << code;
  endfunction

  function automatic logic [NDST-1:0] dst_onehot(input logic [CODE_W-1:0] code);
    return NDST'(1) << code;
  endfunction

endpackage

// File: rtl/xfer_req_fifo.sv
// Synchronous FIFO holding pending (src, dst) transfer requests.
// Head is visible combinationally; a push into an empty FIFO is poppable the next cycle.
module xfer_req_fifo
  import bus_transfer_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         clear,
  input  logic                         push_i,
  input  logic [REQ_W-1:0]             push_data_i,
  input  logic                         pop_i,
  output logic [REQ_W-1:0]             head_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [REQ_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Pointers wrap naturally since DEPTH is a power of two
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/bus_transfer_sequencer.sv
// Queues register-to-register bus transfers and sequences the one-hot source out-enables
// (settle cycle) followed by the destination in-enable (latch cycle) for each one.
module bus_transfer_sequencer
  import bus_transfer_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              req_valid,
  input  logic [4:0]        req_src,
  input  logic [4:0]        req_dst,
  output logic              req_ready,
  output logic [NSRC-1:0]   src_en,
  output logic [NDST-1:0]   dst_en,
  input  logic [31:0]       BusMuxOut,
  output logic              done,
  output logic [31:0]       done_data,
  output logic              err,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  xfer_state_e       state_q, state_d;
  xfer_req_t         cur_q, cur_d;
  logic [NSRC-1:0]   src_en_q, src_en_d;
  logic [NDST-1:0]   dst_en_q, dst_en_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] done_data_q, done_data_d;
  logic              err_q, err_d;

  logic              accept, legal, fifo_push, fifo_pop;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [REQ_W-1:0]  fifo_head_bits;
  xfer_req_t         fifo_head;
  xfer_req_t         req_in;

  // Illegal codes are consumed (handshake completes) but never enter the queue
  assign req_in    = '{src: req_src, dst: req_dst};
  assign legal     = code_legal(req_src, req_dst);
  assign accept    = req_valid && req_ready;
  assign fifo_push = accept && legal;
  assign err_d     = accept && !legal;
  assign fifo_head = xfer_req_t'(fifo_head_bits);

  xfer_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock       (clock),
    .clear       (clear),
    .push_i      (fifo_push),
    .push_data_i (REQ_W'(req_in)),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head_bits),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // Next-state and registered-output decode; LATCH chains straight into DRIVE when work is queued
  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    src_en_d    = '0;
    dst_en_d    = '0;
    done_d      = 1'b0;
    done_data_d = done_data_q;
    fifo_pop    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cur_d    = fifo_head;
          src_en_d = src_onehot(fifo_head.src);
          state_d  = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        src_en_d = src_onehot(cur_q.src);
        dst_en_d = dst_onehot(cur_q.dst);
        state_d  = ST_LATCH;
      end
      ST_LATCH: begin
        done_d      = 1'b1;
        done_data_d = BusMuxOut;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cur_d    = fifo_head;
          src_en_d = src_onehot(fifo_head.src);
          state_d  = ST_DRIVE;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q     <= ST_IDLE;
      cur_q       <= '0;
      src_en_q    <= '0;
      dst_en_q    <= '0;
      done_q      <= 1'b0;
      done_data_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      src_en_q    <= src_en_d;
      dst_en_q    <= dst_en_d;
      done_q      <= done_d;
      done_data_q <= done_data_d;
      err_q       <= err_d;
    end
  end

  assign req_ready = !fifo_full;
  assign busy      = (fifo_count != '0) || (state_q != ST_IDLE);
  assign src_en    = src_en_q;
  assign dst_en    = dst_en_q;
  assign done      = done_q;
  assign done_data = done_data_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Bench for bus_transfer_sequencer: timeline model of accepted transfers plus directed literal checks.
module tb_bus_transfer_sequencer;

  localparam int DEPTH = 4;
  localparam int MAXC  = 512;

  logic        clock = 1'b0;
  logic        clear;
  logic        req_valid;
  logic [4:0]  req_src;
  logic [4:0]  req_dst;
  logic        req_ready;
  logic [23:0] src_en;
  logic [22:0] dst_en;
  logic [31:0] bus_in;
  logic        done;
  logic [31:0] done_data;
  logic        err;
  logic        busy;

  always #5 clock = ~clock;

  bus_transfer_sequencer #(.DEPTH(DEPTH)) dut (
    .clock     (clock),
    .clear     (clear),
    .req_valid (req_valid),
    .req_src   (req_src),
    .req_dst   (req_dst),
    .req_ready (req_ready),
    .src_en    (src_en),
    .dst_en    (dst_en),
    .BusMuxOut (bus_in),
    .done      (done),
    .done_data (done_data),
    .err       (err),
    .busy      (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit started = 1'b0;
  int done_seen = 0;
  int notready_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Model: each accepted legal request owns a drive cycle d; it is queued from its accept
  // edge until d, enables show during d and d+1, done during d+2. Transfers serialize 2 cycles apart.
  typedef struct { int acc; int d; } ent_t;
  ent_t        ents[$];
  logic [23:0] exp_src  [MAXC];
  logic [22:0] exp_dst  [MAXC];
  bit          exp_done [MAXC];
  bit          exp_err  [MAXC];
  logic [31:0] last_data;
  int          free_c;

  function automatic int pending(input int t);
    int n = 0;
    foreach (ents[i]) if (ents[i].acc <= t && ents[i].d > t) n++;
    return n;
  endfunction

  function automatic bit busy_pred(input int t);
    foreach (ents[i]) if (ents[i].acc <= t && ents[i].d + 1 >= t) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clock) begin
    int k, dc;
    bit rdy;
    cyc = cyc + 1;
    k   = cyc;
    rdy = (pending(k - 1) < DEPTH);
    if (clear) begin
      started   = 1'b1;
      ents.delete();
      free_c    = 0;
      last_data = '0;
      for (int i = k; i < MAXC; i++) begin
        exp_src[i]  = '0;
        exp_dst[i]  = '0;
        exp_done[i] = 1'b0;
        exp_err[i]  = 1'b0;
      end
    end else begin
      if (k < MAXC && exp_done[k]) last_data = bus_in;
      if (req_valid && rdy) begin
        if (int'(req_src) < 24 && int'(req_dst) < 23) begin
          dc = (k + 1 > free_c) ? k + 1 : free_c;
          if (dc + 2 < MAXC) begin
            exp_src[dc]     = 24'(1) << req_src;
            exp_src[dc + 1] = 24'(1) << req_src;
            exp_dst[dc + 1] = 23'(1) << req_dst;
            exp_done[dc + 2] = 1'b1;
          end
          free_c = dc + 2;
          ents.push_back('{acc: k, d: dc});
        end else if (k < MAXC) begin
          exp_err[k] = 1'b1;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (started && cyc < MAXC) begin
      chk("src_en",    32'(src_en),    32'(exp_src[cyc]));
      chk("dst_en",    32'(dst_en),    32'(exp_dst[cyc]));
      chk("done",      32'(done),      32'(exp_done[cyc]));
      chk("done_data", done_data,      last_data);
      chk("err",       32'(err),       32'(exp_err[cyc]));
      chk("busy",      32'(busy),      32'(busy_pred(cyc)));
      chk("req_ready", 32'(req_ready), 32'(pending(cyc) < DEPTH));
      if (done === 1'b1) done_seen++;
      if (req_ready === 1'b0) notready_seen++;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic present(input logic [4:0] s, input logic [4:0] d);
    req_valid = 1'b1;
    req_src   = s;
    req_dst   = d;
  endtask

  logic [4:0] t4_src [8] = '{5'd2, 5'd4, 5'd6, 5'd16, 5'd17, 5'd20, 5'd21, 5'd23};
  logic [4:0] t4_dst [8] = '{5'd3, 5'd5, 5'd7, 5'd17, 5'd16, 5'd18, 5'd19, 5'd22};
  logic [4:0] mx_src [5] = '{5'd3, 5'd22, 5'd19, 5'd18, 5'd15};
  logic [4:0] mx_dst [5] = '{5'd3, 5'd22, 5'd0,  5'd21, 5'd15};
  int         mx_gap [5] = '{0, 2, 0, 1, 3};

  initial begin
    int d0, n0;
    clear = 1'b1; req_valid = 1'b0; req_src = '0; req_dst = '0; bus_in = '0;

    // Reset held two cycles
    tick(); tick();
    chk("rst_src_en", 32'(src_en), 32'h0);
    chk("rst_dst_en", 32'(dst_en), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_done_data", done_data, 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h1);
    clear = 1'b0;

    // Single move R0 -> R1
    present(5'd0, 5'd1); bus_in = 32'd12;
    tick(); req_valid = 1'b0;
    tick();
    chk("t2_drive_src", 32'(src_en), 32'h000001);
    chk("t2_drive_dst", 32'(dst_en), 32'h000000);
    tick();
    chk("t2_latch_src", 32'(src_en), 32'h000001);
    chk("t2_latch_dst", 32'(dst_en), 32'h000002);
    tick();
    chk("t2_done", 32'(done), 32'h1);
    chk("t2_done_data", done_data, 32'd12);
    chk("t2_idle_src", 32'(src_en), 32'h0);
    tick(); tick();

    // Back-to-back R1 -> HI then PC -> MAR
    present(5'd1, 5'd16);
    tick(); present(5'd20, 5'd20);
    tick(); req_valid = 1'b0;
    chk("t3_a_drive_src", 32'(src_en), 32'h000002);
    tick();
    chk("t3_a_latch_dst", 32'(dst_en), 32'h010000);
    bus_in = 32'hAAAA0001;
    tick();
    chk("t3_a_done", 32'(done), 32'h1);
    chk("t3_a_data", done_data, 32'hAAAA0001);
    chk("t3_b_drive_src", 32'(src_en), 32'h100000);
    chk("t3_b_drive_dst", 32'(dst_en), 32'h0);
    tick();
    chk("t3_b_latch_dst", 32'(dst_en), 32'h100000);
    bus_in = 32'hBBBB0002;
    tick();
    chk("t3_b_done", 32'(done), 32'h1);
    chk("t3_b_data", done_data, 32'hBBBB0002);
    tick(); tick();

    // Saturate the queue: 8 consecutive requests, only 7 fit
    d0 = done_seen; n0 = notready_seen;
    for (int i = 0; i < 8; i++) begin
      present(t4_src[i], t4_dst[i]);
      bus_in = 32'hC0DE0000 + 32'(i);
      tick();
      if (i == 6) chk("t4_full_ready", 32'(req_ready), 32'h0);
    end
    req_valid = 1'b0;
    repeat (14) tick();
    chk("t4_done_count", 32'(done_seen - d0), 32'd7);
    chk("t4_notready_cycles", 32'(notready_seen - n0), 32'd1);

    // Illegal codes, then a done and an err in the same cycle
    present(5'd24, 5'd3);
    tick();
    chk("t5_err_src", 32'(err), 32'h1);
    chk("t5_no_src_en", 32'(src_en), 32'h0);
    present(5'd2, 5'd23);
    tick();
    chk("t5_err_dst", 32'(err), 32'h1);
    chk("t5_not_busy", 32'(busy), 32'h0);
    present(5'd3, 5'd3);
    tick(); req_valid = 1'b0;
    chk("t5_err_clear", 32'(err), 32'h0);
    tick();
    chk("t5_same_src", 32'(src_en), 32'h000008);
    tick();
    chk("t5_same_dst", 32'(dst_en), 32'h000008);
    bus_in = 32'h5A5A0003;
    present(5'd31, 5'd0);
    tick(); req_valid = 1'b0;
    chk("t5_both_done", 32'(done), 32'h1);
    chk("t5_both_err", 32'(err), 32'h1);
    chk("t5_both_data", done_data, 32'h5A5A0003);
    tick(); tick();

    // Mixed requests with gaps
    for (int i = 0; i < 5; i++) begin
      present(mx_src[i], mx_dst[i]);
      bus_in = $urandom;
      tick();
      req_valid = 1'b0;
      for (int g = 0; g < mx_gap[i]; g++) begin
        bus_in = $urandom;
        tick();
      end
    end
    repeat (12) begin
      bus_in = $urandom;
      tick();
    end

    // clear while R5 -> Y is in its drive cycle
    present(5'd5, 5'd21);
    tick(); req_valid = 1'b0;
    tick();
    chk("t6_drive_src", 32'(src_en), 32'h000020);
    clear = 1'b1;
    tick(); clear = 1'b0;
    chk("t6_src_dropped", 32'(src_en), 32'h0);
    chk("t6_dst_dropped", 32'(dst_en), 32'h0);
    chk("t6_not_busy", 32'(busy), 32'h0);
    chk("t6_done_low", 32'(done), 32'h0);
    tick();
    chk("t6_no_done", 32'(done), 32'h0);
    chk("t6_data_reset", done_data, 32'h0);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
